cbc_msg_sequencer: RTL and testbench
====================================

CBC_MSG_SEQUENCER -- requirements
Module: cbc_msg_sequencer

Interface
REQ-001 Parameter: CNT_W, 16, width of the per-message block counter.
REQ-002 Ports: clk, input, 1, clock; all state is updated on the rising edge.
REQ-003 Ports: reset, input, 1, asynchronous active-high reset.
REQ-004 Ports: cfg_valid / cfg_ready, input / output, 1 each, message-configuration handshake.
REQ-005 Ports: cfg_encrypt, input, 1, mode select (1 encrypt, 0 decrypt); cfg_iv, input, 128, initialization vector.
REQ-006 Ports: s_valid / s_ready, input / output, 1 each, upstream block handshake; s_data, input, 128, block; s_last, input, 1, final block of message.
REQ-007 Ports: eng_start, output, 1; eng_encrypt_n_decrypt, output, 1; eng_iv, output, 128; eng_data_in, output, 128; eng_data_valid, output, 1. These drive the CBC engine.
REQ-008 Ports: eng_data_out, input, 128, engine result; eng_ready, input, 1, engine can accept a block.
REQ-009 Ports: m_valid / m_ready, output / input, 1 each, downstream handshake; m_data, output, 128, result block; m_last, output, 1, final result of message.
REQ-010 Ports: done, output, 1, one-cycle pulse at message end; blk_count, output, CNT_W, blocks processed in the current or last message; ovf, output, 1, sticky counter-saturation flag.

Function
REQ-011 The FSM SHALL have the states IDLE, START, FEED, WAIT, DRAIN.
REQ-012 IDLE: cfg_ready=1, and cfg_ready SHALL be 0 in every other state.
  - On cfg_valid, latch cfg_encrypt and cfg_iv, clear blk_count and ovf, then go to START.
REQ-013 START: assert eng_start=1 for exactly one cycle, with eng_iv equal to the latched IV, then go to FEED.
REQ-014 eng_encrypt_n_decrypt and eng_iv SHALL continuously reflect the latched values.
REQ-015 FEED: s_ready = eng_ready AND the output register is empty (or being emptied this cycle by m_valid&&m_ready).
  - eng_data_valid = s_valid && s_ready (combinational).
  - eng_data_in = s_data (passthrough).
REQ-016 On a FEED transfer, latch s_last into last_q and go to WAIT.
REQ-017 WAIT (one cycle): on the next edge, capture eng_data_out into the output register.
  - Set m_valid=1 and m_last=last_q.
  - Increment blk_count.
  - Go to DRAIN if last_q, else to FEED.
REQ-018 Latency: a block accepted in cycle N SHALL appear with m_valid=1 in cycle N+2.
REQ-019 The output register SHALL hold m_data and m_last stable while m_valid && !m_ready; it clears on m_valid&&m_ready.
REQ-020 At most one block SHALL be in flight; s_ready=0 in IDLE, START, WAIT and DRAIN.
REQ-021 DRAIN: wait until the final output is accepted (m_valid&&m_ready), pulse done=1 in the following cycle, then go to IDLE.
REQ-022 blk_count SHALL saturate at 2^CNT_W-1.
  - An increment attempted at saturation sets ovf=1.
  - ovf and the count hold until the next cfg accept.
REQ-023 A message of a single block (s_last on the first block) SHALL produce exactly one output with m_last=1.
REQ-024 eng_ready low in FEED SHALL stall with s_ready=0 and no state change.
REQ-025 cfg_valid outside IDLE SHALL be ignored, and no configuration register changes.

Reset
REQ-026 On reset assertion, regardless of the current state:
  - FSM goes to IDLE.
  - m_valid, m_last, done, eng_start, eng_data_valid, s_ready, ovf are 0.
  - blk_count=0, m_data=0, latched IV=0, latched mode=0.
  - cfg_ready=1.
REQ-027 Reset mid-message SHALL discard the in-flight block and any pending output; no done pulse is produced.

Verification
REQ-028 3-block encrypt: cfg_iv=0x000102...0F, blocks A,B,C with s_last on C, m_ready=1 -> eng_start pulses once; three outputs each 2 cycles after acceptance; m_last only on C; done one cycle after C is accepted; blk_count=3.
REQ-029 Single-block decrypt with cfg_encrypt=0 -> eng_encrypt_n_decrypt=0; one output with m_last=1; done pulse; blk_count=1.
REQ-030 Backpressure: m_ready=0 for 5 cycles after the first output -> m_data stable; s_ready=0 throughout; transfer completes when m_ready=1.
REQ-031 eng_ready=0 for 3 cycles in FEED while s_valid=1 -> no eng_data_valid; block accepted in the first cycle eng_ready=1.
REQ-032 Saturation: CNT_W=2, 5-block message -> blk_count stops at 3; ovf=1 after the 4th block.
REQ-033 Reset asserted in WAIT -> all outputs at reset values; no m_valid or done; a new cfg accepted afterwards runs normally.

Source files
------------

// File: rtl/cbc_msg_sequencer.sv
// -----------------------------------------------------------------------------
// cbc_msg_sequencer
// Sequences one CBC message through an external block-cipher engine. A message
// is configured with mode and IV, then its blocks are passed to the engine one
// at a time. Each result is held in a single output register until downstream
// accepts it. The block counter saturates and sets a sticky overflow flag.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   cfg_valid/cfg_ready    message configuration handshake (cfg_encrypt, cfg_iv)
//   s_valid/s_ready        upstream block handshake (s_data, s_last)
//   eng_*                  engine control/data (start, mode, IV, block in/out)
//   m_valid/m_ready        downstream result handshake (m_data, m_last)
//   done                   one-cycle pulse after the final result is taken
//   blk_count, ovf         saturating block counter and sticky overflow flag
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a configuration; cfg_ready high
// START   | one-cycle eng_start pulse with the latched IV
// FEED    | offer one upstream block to the engine
// WAIT    | engine result captured into the output register on exit
// DRAIN   | final result waiting for downstream; done follows acceptance
// -----------------------------------------------------------------------------
module cbc_msg_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_encrypt,
    input  logic [127:0]       cfg_iv,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [127:0]       s_data,
    input  logic               s_last,
    output logic               eng_start,
    output logic               eng_encrypt_n_decrypt,
    output logic [127:0]       eng_iv,
    output logic [127:0]       eng_data_in,
    output logic               eng_data_valid,
    input  logic [127:0]       eng_data_out,
    input  logic               eng_ready,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [127:0]       m_data,
    output logic               m_last,
    output logic               done,
    output logic [CNT_W-1:0]   blk_count,
    output logic               ovf
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FEED,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               mode_q;
    logic [127:0]       iv_q;
    logic               last_q;
    logic [127:0]       data_q;
    logic               valid_q;
    logic               mlast_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic               cfg_accept;
    logic               feed_xfer;
    logic               out_xfer;
    logic               out_free;
    logic               cnt_sat;

    assign out_xfer = valid_q && m_ready;
    // The output register can take a new result if it is empty or is being
    // drained in this very cycle.
    assign out_free = !valid_q || m_ready;
    assign cnt_sat  = &cnt_q;

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        cfg_accept = 1'b0;
        s_ready    = 1'b0;
        feed_xfer  = 1'b0;
        eng_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cfg_accept = 1'b1;
                    state_nxt  = ST_START;
                end
            end
            ST_START: begin
                eng_start = 1'b1;
                state_nxt = ST_FEED;
            end
            ST_FEED: begin
                s_ready   = eng_ready && out_free;
                feed_xfer = s_valid && eng_ready && out_free;
                if (feed_xfer) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_nxt = last_q ? ST_DRAIN : ST_FEED;
            end
            ST_DRAIN: begin
                if (out_xfer) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= 1'b0;
            iv_q    <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            mlast_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= (state == ST_DRAIN) && out_xfer;

            if (cfg_accept) begin
                mode_q <= cfg_encrypt;
                iv_q   <= cfg_iv;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end

            if (feed_xfer) begin
                last_q <= s_last;
            end

            // The register is always empty in WAIT because FEED only hands a
            // block over when it is free, so loading has no conflict with
            // an in-progress drain.
            if (state == ST_WAIT) begin
                data_q  <= eng_data_out;
                valid_q <= 1'b1;
                mlast_q <= last_q;
                if (cnt_sat) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (out_xfer) begin
                valid_q <= 1'b0;
                mlast_q <= 1'b0;
            end
        end
    end

    assign eng_encrypt_n_decrypt = mode_q;
    assign eng_iv                = iv_q;
    assign eng_data_in           = s_data;
    assign eng_data_valid        = feed_xfer;

    assign m_valid   = valid_q;
    assign m_data    = data_q;
    assign m_last    = mlast_q;
    assign done      = done_q;
    assign blk_count = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cbc_msg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cbc_msg_sequencer
// Drives directed and random messages into two sequencer instances (default
// counter width and a 2-bit counter) that share all inputs. A toy CBC engine
// answers the engine interface; expected results, latency, hold behaviour,
// done pulses and counter/overflow values come from a message-level model.
// -----------------------------------------------------------------------------
module tb_cbc_msg_sequencer;

    localparam logic [127:0] KEY = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam int MAX1 = 65535;
    localparam int MAX2 = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_valid, cfg_encrypt;
    logic [127:0] cfg_iv;
    logic         s_valid, s_last;
    logic [127:0] s_data;
    logic [127:0] eng_data_out = '0;
    logic         eng_ready = 1'b0;
    logic         m_ready = 1'b0;

    logic         cfg_ready, s_ready, eng_start, eng_encrypt_n_decrypt, eng_data_valid;
    logic [127:0] eng_iv, eng_data_in, m_data;
    logic         m_valid, m_last, done, ovf;
    logic [15:0]  blk_count;

    logic         d2_cfg_ready, d2_s_ready, d2_eng_start, d2_eng_mode, d2_eng_dv;
    logic [127:0] d2_eng_iv, d2_eng_din, d2_m_data;
    logic         d2_m_valid, d2_m_last, d2_done, d2_ovf;
    logic [1:0]   d2_blk_count;

    cbc_msg_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_encrypt(cfg_encrypt), .cfg_iv(cfg_iv),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .eng_start(eng_start), .eng_encrypt_n_decrypt(eng_encrypt_n_decrypt), .eng_iv(eng_iv),
        .eng_data_in(eng_data_in), .eng_data_valid(eng_data_valid),
        .eng_data_out(eng_data_out), .eng_ready(eng_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done), .blk_count(blk_count), .ovf(ovf)
    );

    cbc_msg_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(d2_cfg_ready), .cfg_encrypt(cfg_encrypt), .cfg_iv(cfg_iv),
        .s_valid(s_valid), .s_ready(d2_s_ready), .s_data(s_data), .s_last(s_last),
        .eng_start(d2_eng_start), .eng_encrypt_n_decrypt(d2_eng_mode), .eng_iv(d2_eng_iv),
        .eng_data_in(d2_eng_din), .eng_data_valid(d2_eng_dv),
        .eng_data_out(eng_data_out), .eng_ready(eng_ready),
        .m_valid(d2_m_valid), .m_ready(m_ready), .m_data(d2_m_data), .m_last(d2_m_last),
        .done(d2_done), .blk_count(d2_blk_count), .ovf(d2_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] enc_f(input logic [127:0] x);
        return {x[126:0], x[127]} ^ KEY;
    endfunction

    function automatic logic [127:0] dec_f(input logic [127:0] x);
        logic [127:0] y;
        y = x ^ KEY;
        return {y[0], y[127:1]};
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in CBC engine: chain restarts from eng_iv on eng_start.
    logic [127:0] eng_chain = '0;
    always @(posedge clk) begin
        if (eng_start) eng_chain <= eng_iv;
        if (eng_data_valid) begin
            if (eng_encrypt_n_decrypt) begin
                eng_data_out <= enc_f(eng_data_in ^ eng_chain);
                eng_chain    <= enc_f(eng_data_in ^ eng_chain);
            end else begin
                eng_data_out <= dec_f(eng_data_in) ^ eng_chain;
                eng_chain    <= eng_data_in;
            end
        end
    end

    // Handshake pacing for m_ready / eng_ready.
    int mr_pct = 100, er_pct = 100, er_hold = 0, bp_cnt = 0;
    bit bp_arm = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bp_arm) begin
            if (m_valid) bp_cnt++;
            if (bp_cnt >= 6) begin
                bp_arm  = 1'b0;
                m_ready = 1'b1;
            end else begin
                m_ready = 1'b0;
            end
        end else begin
            m_ready = ($urandom_range(99) < mr_pct);
        end
        if (er_hold > 0) begin
            eng_ready = 1'b0;
            er_hold--;
        end else begin
            eng_ready = ($urandom_range(99) < er_pct);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor / scoreboard
    logic [127:0] exp_data_q[$];
    bit           exp_last_q[$];
    int           acc_q[$];
    logic [127:0] mdl_iv = '0, prev_data = '0;
    bit           mdl_enc = 1'b0, prev_hold = 1'b0, prev_last = 1'b0, done_exp = 1'b0;
    int           nout = 0, start_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_data_q.delete();
            exp_last_q.delete();
            acc_q.delete();
            prev_hold = 1'b0;
            done_exp  = 1'b0;
            chk("rst_m_valid", m_valid, 0);
            chk("rst_done", done, 0);
        end else begin
            chk("done", done, done_exp);
            done_exp = 1'b0;
            chk("eng_data_valid", eng_data_valid, s_valid && s_ready);
            if (!eng_ready || (m_valid && !m_ready)) chk("s_ready_blocked", s_ready, 0);
            if (cfg_valid && cfg_ready) begin
                nout = 0;
                start_cnt = 0;
            end
            if (eng_start) begin
                start_cnt++;
                chk("eng_iv", eng_iv, mdl_iv);
                chk("eng_mode", eng_encrypt_n_decrypt, mdl_enc);
            end
            if (eng_data_valid) acc_q.push_back(cyc);
            if (m_valid && !prev_hold) begin
                nout++;
                if (acc_q.size() == 0) chk("latency_orphan", 1, 0);
                else chk("latency", cyc - acc_q.pop_front(), 2);
                chk("blk_count", blk_count, sat(nout, MAX1));
                chk("blk_count_w2", d2_blk_count, sat(nout, MAX2));
                chk("ovf_w2", d2_ovf, nout > MAX2);
            end
            if (prev_hold) begin
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (exp_data_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("m_data", m_data, exp_data_q.pop_front());
                    chk("m_last", m_last, exp_last_q.pop_front());
                end
                if (m_last) done_exp = 1'b1;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    task automatic check_reset_outputs();
        chk("r_cfg_ready", cfg_ready, 1);
        chk("r_m_valid", m_valid, 0);
        chk("r_m_last", m_last, 0);
        chk("r_done", done, 0);
        chk("r_eng_start", eng_start, 0);
        chk("r_eng_dv", eng_data_valid, 0);
        chk("r_s_ready", s_ready, 0);
        chk("r_ovf", ovf, 0);
        chk("r_blk_count", blk_count, 0);
        chk("r_m_data", m_data, 0);
        chk("r_eng_iv", eng_iv, 0);
        chk("r_eng_mode", eng_encrypt_n_decrypt, 0);
        chk("r_blk_count_w2", d2_blk_count, 0);
    endtask

    // One message: len blocks; stall holds eng_ready low for 3 FEED cycles on
    // the first block; bp holds m_ready low after the first result; junk drives
    // garbage configuration while the message runs; rst_at resets the design
    // in WAIT after that block index is accepted.
    task automatic run_msg(input int len, input bit enc, input logic [127:0] iv,
                           input bit stall, input bit bp, input bit junk, input int rst_at);
        logic [127:0] blk[$];
        logic [127:0] expd[$];
        logic [127:0] chain, d, r;
        int waits;
        bit xfer;
        chain = iv;
        for (int i = 0; i < len; i++) begin
            d = rnd128();
            if (enc) begin
                r = enc_f(d ^ chain);
                chain = r;
            end else begin
                r = dec_f(d) ^ chain;
                chain = d;
            end
            blk.push_back(d);
            expd.push_back(r);
        end

        waits = 0;
        @(negedge clk);
        while (!cfg_ready && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        chk("cfg_ready_wait", cfg_ready, 1);
        mdl_iv  = iv;
        mdl_enc = enc;
        if (bp) begin
            bp_cnt = 0;
            bp_arm = 1'b1;
        end
        cfg_valid   = 1'b1;
        cfg_encrypt = enc;
        cfg_iv      = iv;
        @(posedge clk);
        #2;
        cfg_valid = 1'b0;
        if (stall) er_hold = 3;

        for (int i = 0; i < len; i++) begin
            if (junk) begin
                cfg_valid   = $urandom_range(1);
                cfg_encrypt = $urandom_range(1);
                cfg_iv      = rnd128();
            end
            if (!stall) begin
                s_valid = 1'b0;
                repeat ($urandom_range(2)) begin
                    @(posedge clk);
                    #2;
                end
            end
            s_valid = 1'b1;
            s_data  = blk[i];
            s_last  = (i == len - 1);
            exp_data_q.push_back(expd[i]);
            exp_last_q.push_back(i == len - 1);
            waits = 0;
            xfer  = 1'b0;
            while (!xfer && waits < 1000) begin
                @(negedge clk);
                xfer = s_valid && s_ready;
                @(posedge clk);
                #2;
                waits++;
            end
            chk("xfer_timeout", xfer, 1);
            if (stall && i == 0) chk("stall_accept_cycle", waits, 5);
            s_valid = 1'b0;
            if (i == rst_at) begin
                cfg_valid = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_outputs();
                repeat (3) @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        cfg_valid = 1'b0;

        waits = 0;
        @(negedge clk);
        while (!done && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        chk("done_seen", done, 1);
        chk("end_blk_count", blk_count, sat(len, MAX1));
        chk("end_ovf", ovf, 0);
        chk("end_blk_count_w2", d2_blk_count, sat(len, MAX2));
        chk("end_ovf_w2", d2_ovf, len > MAX2);
        chk("eng_start_count", start_cnt, 1);
        chk("outputs_pending", exp_data_q.size(), 0);
        chk("end_cfg_ready", cfg_ready, 1);
    endtask

    initial begin
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_encrypt = 1'b0;
        cfg_iv      = '0;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        s_data      = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);

        run_msg(3, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 0, 0, 0, -1);
        run_msg(1, 1'b0, rnd128(), 0, 0, 0, -1);
        run_msg(3, 1'b1, rnd128(), 0, 1, 0, -1);
        run_msg(2, 1'b1, rnd128(), 1, 0, 0, -1);
        run_msg(5, 1'b0, rnd128(), 0, 0, 0, -1);
        run_msg(3, 1'b1, rnd128(), 0, 0, 0, 0);
        run_msg(2, 1'b1, rnd128(), 0, 0, 1, -1);

        for (int k = 0; k < 15; k++) begin
            mr_pct = $urandom_range(100, 30);
            er_pct = $urandom_range(100, 40);
            run_msg($urandom_range(7, 1), $urandom_range(1), rnd128(), 0, 0, 1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
